mac_acc: RTL and testbench
==========================

// Module: mac_acc
//
// PURPOSE
// Signed multiply-accumulate unit for the SNN datapath.
// Each clock it multiplies two signed operands and adds the product into a
// wide signed accumulator register.
// A synchronous clear starts a new dot product; an asynchronous reset
// initialises the block.
// Used wherever neuron weight x input sums are formed.
//
// PARAMETERS
// IN_W   8   width of each signed operand (two's complement)
// ACC_W  26  width of the signed accumulator; must be >= 2*IN_W
//
// PORTS
// clk    in   1      single clock; all state updates on the rising edge
// rst    in   1      asynchronous, active-high reset
// clr_n  in   1      synchronous, active-low accumulator clear
// in1    in   IN_W   signed operand A
// in2    in   IN_W   signed operand B
// acc    out  ACC_W  signed accumulator value (registered)
//
// BEHAVIOUR
// - Reset: rst high forces acc = 0 immediately, independent of clk.
//   Reset is released asynchronously; the first update is on the next rising edge.
// - Priority at each rising edge: rst > clr_n low > accumulate.
// - clr_n low at a rising edge: acc <= 0. The product of that cycle is discarded.
// - Otherwise: acc <= acc + sext(in1*in2) at every rising edge. There is no enable.
//   Holding inputs constant therefore accumulates the same product each cycle.
// - Product: full 2*IN_W-bit signed product, formed combinationally.
//   It is sign-extended to ACC_W before the add.
// - Latency: inputs sampled at edge N appear on acc right after edge N.
//   acc is valid by the following falling edge.
// - Overflow: default arithmetic is modulo 2^ACC_W (two's-complement wrap).
//   acc equals the low ACC_W bits of the exact integer sum.
// - Extremes: in1 = in2 = -128 gives +16384; this product must not be negated wrongly.
// - acc is driven only from the register; no combinational path from inputs to acc.
//
// CONFIGURATION
// MAC_SATURATE_EN defined:
// - The add saturates instead of wrapping.
// - Positive overflow clamps acc to 2^(ACC_W-1)-1; negative overflow clamps to -2^(ACC_W-1).
// - Detection uses an ACC_W+1-bit sum.
// - Clear and reset behaviour are unchanged.
// MAC_SATURATE_EN undefined: modulo wrap as described above.
//
// TESTING
// 1. rst=1 then release, clr_n pulse -> acc = 0.
//    Apply (2,5), (-2,5), (-3,8) on three edges -> acc = 10, 0, -24.
// 2. clr_n low one edge, then (126,126) held for 3 edges -> acc = 15876, 31752, 47628.
// 3. Clear, then (126,-100) held for 6 edges -> acc = -12600, -25200, ..., -75600.
//    Each value is checked at the negedge.
// 4. Clear priority: clr_n=0 with in1=in2=100 on the same edge -> acc = 0, not 10000.
// 5. Reset mid-run: acc = 47628, assert rst between edges -> acc = 0 immediately.
//    It stays 0 while rst is high, even with nonzero inputs.
// 6. Wrap: (-128,-128) held for 2048 edges.
//    Without MAC_SATURATE_EN -> acc = -33554432.
//    With MAC_SATURATE_EN -> acc = 33554431 and it stays there.

Source files
------------

// File: rtl/mac_acc.sv
// Signed multiply-accumulate: acc <= acc + sext(in1*in2) every rising edge.
// Define MAC_SATURATE_EN to clamp the accumulate instead of wrapping modulo 2^ACC_W.
module mac_acc #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 26
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_n,
  input  logic signed [IN_W-1:0]  in1,
  input  logic signed [IN_W-1:0]  in2,
  output logic signed [ACC_W-1:0] acc
);

  localparam int PROD_W = 2 * IN_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_nxt;

  // Widen both operands first so -128 * -128 yields +16384 rather than truncating.
  always_comb begin
    prod     = PROD_W'(in1) * PROD_W'(in2);
    prod_ext = ACC_W'(prod);
  end

`ifdef MAC_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] sum_w;

  // The two top bits of the extended sum disagree exactly when the add overflowed.
  always_comb begin
    sum_w   = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
    acc_nxt = sum_w[ACC_W-1:0];
    if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
      acc_nxt = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  always_comb begin
    acc_nxt = acc + prod_ext;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (!clr_n) begin
      acc <= '0;
    end else begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_mac_acc.sv
// Scoreboard bench for mac_acc: expected acc values are queued when inputs are
// driven and popped at the following falling edge.
module tb_mac_acc;

  localparam int IN_W  = 8;
  localparam int ACC_W = 26;

  logic                    clk;
  logic                    rst;
  logic                    clr_n;
  logic signed [IN_W-1:0]  in1;
  logic signed [IN_W-1:0]  in2;
  logic signed [ACC_W-1:0] acc;

  int n_cmp = 0;
  int n_bad = 0;

  longint model_acc;
  longint exp_q[$];

  mac_acc #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .clr_n(clr_n),
    .in1  (in1),
    .in2  (in2),
    .acc  (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint fold(input longint v);
    longint half;
    longint full;
    longint m;
    half = longint'(1) <<< (ACC_W - 1);
    full = longint'(1) <<< ACC_W;
`ifdef MAC_SATURATE_EN
    if (v > half - 1) return half - 1;
    if (v < -half) return -half;
    return v;
`else
    m = v % full;
    if (m < 0) m = m + full;
    if (m >= half) m = m - full;
    return m;
`endif
  endfunction

  // Called at a falling edge: applies inputs for the next rising edge, queues the
  // expected result, and returns at the following falling edge.
  task automatic drive(input int a, input int b, input bit clr);
    in1   = IN_W'(a);
    in2   = IN_W'(b);
    clr_n = ~clr;
    if (clr) model_acc = 0;
    else     model_acc = fold(model_acc + longint'(a) * longint'(b));
    exp_q.push_back(model_acc);
    @(negedge clk);
  endtask

  function automatic longint acc_val();
    return longint'(acc);
  endfunction

  task automatic test_reset();
    longint got, exp;
    rst = 1'b1; clr_n = 1'b1; in1 = 8'sd7; in2 = 8'sd9;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (acc_val() !== 0) begin
      n_bad++;
      $display("FAIL reset_hold: acc=%0d expected=0", acc_val());
    end
    rst = 1'b0;
    model_acc = 0;
    exp_q.delete();
    drive(0, 0, 1'b1);
    drive(2, 5, 1'b0);
    drive(-2, 5, 1'b0);
    drive(-3, 8, 1'b0);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (exp_q.size() == 0) begin
        got = acc_val();
        if (got !== exp || got !== -24) begin
          n_bad++;
          $display("FAIL basic_seq: acc=%0d expected=%0d", got, exp);
        end
      end
    end
  endtask

  task automatic test_hold_pos();
    longint got, exp;
    drive(0, 0, 1'b1);
    n_cmp++;
    exp = exp_q.pop_front(); got = acc_val();
    if (got !== exp) begin n_bad++; $display("FAIL clr_before_pos: acc=%0d expected=%0d", got, exp); end
    for (int i = 0; i < 3; i++) begin
      drive(126, 126, 1'b0);
      exp = exp_q.pop_front(); got = acc_val();
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL hold_pos_%0d: acc=%0d expected=%0d", i, got, exp); end
    end
    n_cmp++;
    if (acc_val() !== 47628) begin n_bad++; $display("FAIL hold_pos_final: acc=%0d expected=47628", acc_val()); end
  endtask

  task automatic test_hold_neg();
    longint got, exp;
    drive(0, 0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 6; i++) begin
      drive(126, -100, 1'b0);
      exp = exp_q.pop_front(); got = acc_val();
      n_cmp++;
      if (got !== exp || got !== -12600 * (i + 1)) begin
        n_bad++; $display("FAIL hold_neg_%0d: acc=%0d expected=%0d", i, got, exp);
      end
    end
  endtask

  task automatic test_clr_priority();
    longint got, exp;
    drive(3, 3, 1'b0);
    void'(exp_q.pop_front());
    drive(100, 100, 1'b1);
    exp = exp_q.pop_front(); got = acc_val();
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL clr_priority: acc=%0d expected=%0d", got, exp); end
  endtask

  task automatic test_reset_midrun();
    longint got, exp;
    drive(0, 0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive(126, 126, 1'b0);
      void'(exp_q.pop_front());
    end
    n_cmp++;
    if (acc_val() !== 47628) begin n_bad++; $display("FAIL pre_reset: acc=%0d expected=47628", acc_val()); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (acc_val() !== 0) begin n_bad++; $display("FAIL async_reset: acc=%0d expected=0", acc_val()); end
    in1 = 8'sd50; in2 = 8'sd50; clr_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (acc_val() !== 0) begin n_bad++; $display("FAIL reset_held_%0d: acc=%0d expected=0", i, acc_val()); end
    end
    rst = 1'b0;
    model_acc = 0;
    drive(4, -4, 1'b0);
    exp = exp_q.pop_front(); got = acc_val();
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL after_reset: acc=%0d expected=%0d", got, exp); end
  endtask

  task automatic test_wrap();
    longint got, exp;
    drive(0, 0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 2050; i++) begin
      drive(-128, -128, 1'b0);
      exp = exp_q.pop_front(); got = acc_val();
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL wrap_%0d: acc=%0d expected=%0d", i, got, exp); end
      if (i == 0) begin
        n_cmp++;
        if (got !== 16384) begin n_bad++; $display("FAIL extreme_prod: acc=%0d expected=16384", got); end
      end
      if (i == 2047) begin
        n_cmp++;
`ifdef MAC_SATURATE_EN
        if (got !== 33554431) begin n_bad++; $display("FAIL wrap_2048: acc=%0d expected=33554431", got); end
`else
        if (got !== -33554432) begin n_bad++; $display("FAIL wrap_2048: acc=%0d expected=-33554432", got); end
`endif
      end
    end
  endtask

  initial begin
    rst = 1'b1; clr_n = 1'b1; in1 = '0; in2 = '0;
    model_acc = 0;
    @(negedge clk);
    test_reset();
    test_hold_pos();
    test_hold_neg();
    test_clr_priority();
    test_reset_midrun();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
